// File: rtl/btn_event_conditioner_if.sv
// btn_event_conditioner_if: event stream handshake (evt_valid/evt_ready/evt_code); master drives valid and code, slave drives ready
interface btn_event_conditioner_if #(parameter int WIDTH = 4);
  logic evt_valid;
  logic evt_ready;
  logic [$clog2(WIDTH):0] evt_code;
  modport master (output evt_valid, evt_code, input evt_ready);
  modport slave (input evt_valid, evt_code, output evt_ready);
endinterface

// File: rtl/btn_event_conditioner.sv
// btn_event_conditioner: sync + debounce buttons, emit rise/fall pulses, queue {edge,channel} events
// ports: clk, rst, ena, btn_in (raw), db_level/rise_pulse/fall_pulse (per channel), evt (valid/ready/code stream), evt_count (occupancy), overflow (sticky lost event)
module btn_event_conditioner #(
  parameter int WIDTH = 4,
  parameter int DB_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] db_level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic overflow,
  btn_event_conditioner_if.master evt
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam int IW = $clog2(WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] s1, s2, done, rise_new, fall_new, rise_pend, fall_pend, rise_clr, fall_clr;
  logic [CW-1:0] cnt [WIDTH];
  logic [IW:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [IW-1:0] sel;
  logic any, sel_rise, push, pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end
  always_comb begin
    done = '0;
    for (int i = 0; i < WIDTH; i++)
      done[i] = ena && (s2[i] != db_level[i]) && (cnt[i] == CW'(DB_CYCLES - 1));
  end
  assign rise_new = done & s2;
  assign fall_new = done & ~s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      rise_pulse <= rise_new;
      fall_pulse <= fall_new;
      if (ena)
        for (int i = 0; i < WIDTH; i++)
          if (s2[i] == db_level[i] || done[i]) cnt[i] <= '0;
          else cnt[i] <= cnt[i] + 1'b1;
      db_level <= db_level ^ done;
    end
  end
  // descending scan so the lowest pending channel is the one left selected
  always_comb begin
    any = 1'b0;
    sel = '0;
    sel_rise = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (rise_pend[i] || fall_pend[i]) begin
        any = 1'b1;
        sel = IW'(i);
        sel_rise = rise_pend[i];
      end
    push = ena && any && (evt_count < (AW + 1)'(FIFO_DEPTH));
    rise_clr = (push && sel_rise) ? WIDTH'(1) << sel : '0;
    fall_clr = (push && !sel_rise) ? WIDTH'(1) << sel : '0;
  end
  // a pulse on a flag that is not drained this edge merges into it and is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_pend <= '0;
      fall_pend <= '0;
      overflow <= 1'b0;
    end else begin
      rise_pend <= (rise_pend & ~rise_clr) | rise_new;
      fall_pend <= (fall_pend & ~fall_clr) | fall_new;
      overflow <= overflow | (|(rise_new & rise_pend & ~rise_clr)) | (|(fall_new & fall_pend & ~fall_clr));
    end
  end
  assign evt.evt_valid = (evt_count != '0);
  assign evt.evt_code = evt.evt_valid ? mem[rptr] : '0;
  assign pop = evt.evt_valid && evt.evt_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      evt_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {sel_rise, sel};
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      evt_count <= evt_count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
endmodule
